pid_ctrl_mc: RTL and testbench

Parametrised, time-multiplexed multi-channel PID controller. It serves N_CH pressure loops, for example one per gripper finger, from one shared multiply datapath. A single-cycle sample strobe in the CLK domain starts each frame; a free-running edge is not used as a clock. Per channel it adds runtime gains and setpoints, shift-based fixed-point scaling, integrator clamping with conditional-integration anti-windup, and overrun detection. Its output stream feeds the valve/PWM drive stage.

---
 rtl/pid_pkg.sv | 21 ++
 rtl/pid_sat.sv | 31 +++
 rtl/pid_ctrl_mc.sv | 219 +++++++++++++++++++++
 tb/tb_pid_ctrl_mc.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and constants for the time-multiplexed PID controller.
package pid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErr,
    StMul,
    StSum,
    StSat
  } pid_state_e;

  localparam int unsigned FracBitsDefault = 7;
  // Extra headroom for i + ki and for p + i + d so neither sum can wrap.
  localparam int unsigned IntGuardBits    = 1;
  localparam int unsigned RawGuardBits    = 2;

  function automatic int unsigned max_w(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed saturator: clips a wide signed value into [LO_LIM, HI_LIM] and flags
// which side clipped.
module pid_sat #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned OUT_W  = 16,
  parameter longint      HI_LIM = 32767,
  parameter longint      LO_LIM = -32768
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    hi_o,
  output logic                    lo_o
);

  localparam logic signed [IN_W-1:0]  HiIn  = IN_W'(HI_LIM);
  localparam logic signed [IN_W-1:0]  LoIn  = IN_W'(LO_LIM);
  localparam logic signed [OUT_W-1:0] HiOut = OUT_W'(HI_LIM);
  localparam logic signed [OUT_W-1:0] LoOut = OUT_W'(LO_LIM);

  always_comb begin
    hi_o  = (in_i > HiIn);
    lo_o  = (in_i < LoIn);
    out_o = in_i[OUT_W-1:0];
    if (hi_o) begin
      out_o = HiOut;
    end else if (lo_o) begin
      out_o = LoOut;
    end
  end

endmodule

// File: rtl/pid_ctrl_mc.sv
// Multi-channel PID controller sharing one datapath; each channel takes four
// cycles (error, multiply, sum, saturate) after a frame-start strobe.
module pid_ctrl_mc
  import pid_pkg::*;
#(
  parameter int unsigned  N_CH      = 4,
  parameter int unsigned  DATA_W    = 16,
  parameter int unsigned  COEF_W    = 16,
  parameter int unsigned  FRAC_BITS = FracBitsDefault,
  parameter int unsigned  ACC_W     = 24,
  parameter int unsigned  OUT_W     = 16,
  parameter longint       INT_LIM   = (longint'(1) << (OUT_W - 1)) - 1,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SAMPLE_EN,
  input  logic [N_CH*DATA_W-1:0]   PV_IN,
  input  logic [N_CH*DATA_W-1:0]   SP_IN,
  input  logic signed [COEF_W-1:0] KP,
  input  logic signed [COEF_W-1:0] KI,
  input  logic signed [COEF_W-1:0] KD,
  output logic signed [OUT_W-1:0]  PID_out,
  output logic                     OUT_VALID,
  output logic [CH_W-1:0]          OUT_CH,
  output logic                     BUSY,
  output logic                     OVERRUN
);

  localparam int unsigned EW     = DATA_W + 1;
  localparam int unsigned DeW    = DATA_W + 2;
  localparam int unsigned ProdW  = COEF_W + DeW;
  localparam int unsigned IsumW  = max_w(ACC_W, ProdW) + IntGuardBits;
  localparam int unsigned RawW   = max_w(ACC_W, ProdW) + RawGuardBits;
  localparam longint      OutMax = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint      OutMin = -(longint'(1) << (OUT_W - 1));

  pid_state_e state_q, state_d;
  logic [CH_W-1:0] ch_q;

  // Frame snapshot
  logic [DATA_W-1:0]        pv_q [N_CH];
  logic [DATA_W-1:0]        sp_q [N_CH];
  logic signed [COEF_W-1:0] kp_q, ki_q, kd_q;

  // Pipeline registers for the channel in flight
  logic signed [EW-1:0]     e_q;
  logic signed [DeW-1:0]    de_q;
  logic signed [ProdW-1:0]  p_q, kie_q, d_q;
  logic signed [ACC_W-1:0]  i_cand_q;
  logic                     u_hi_q, u_lo_q;

  // Per-channel loop state
  logic signed [ACC_W-1:0]  int_q    [N_CH];
  logic signed [EW-1:0]     e_prev_q [N_CH];
  logic [N_CH-1:0]          first_q;

  logic signed [OUT_W-1:0]  pid_out_q;
  logic [CH_W-1:0]          out_ch_q;
  logic                     out_valid_q, overrun_q;

  logic last_ch;
  assign last_ch = (ch_q == CH_W'(N_CH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (SAMPLE_EN) state_d = StErr;
      StErr:   state_d = StMul;
      StMul:   state_d = StSum;
      StSum:   state_d = StSat;
      StSat:   state_d = last_ch ? StIdle : StErr;
      default: state_d = StIdle;
    endcase
  end

  // Error and first-sample-suppressed difference
  logic signed [EW-1:0]  e_d;
  logic signed [DeW-1:0] de_d;
  always_comb begin
    e_d = $signed({1'b0, sp_q[ch_q]}) - $signed({1'b0, pv_q[ch_q]});
    if (first_q[ch_q]) begin
      de_d = '0;
    end else begin
      de_d = DeW'(e_d) - DeW'(e_prev_q[ch_q]);
    end
  end

  // Full-width products; >>> on signed values floors toward -inf
  logic signed [ProdW-1:0] p_d, kie_d, d_d;
  assign p_d   = (ProdW'(kp_q) * ProdW'(e_q)) >>> FRAC_BITS;
  assign kie_d = (ProdW'(ki_q) * ProdW'(e_q)) >>> FRAC_BITS;
  assign d_d   = (ProdW'(kd_q) * ProdW'(de_q)) >>> FRAC_BITS;

  logic signed [IsumW-1:0] isum;
  logic signed [ACC_W-1:0] i_cand;
  logic                    int_hi, int_lo;
  assign isum = IsumW'(int_q[ch_q]) + IsumW'(kie_q);

  pid_sat #(
    .IN_W  (IsumW),
    .OUT_W (ACC_W),
    .HI_LIM(INT_LIM),
    .LO_LIM(-INT_LIM)
  ) u_int_sat (
    .in_i (isum),
    .out_o(i_cand),
    .hi_o (int_hi),
    .lo_o (int_lo)
  );

  logic unused_int_clip;
  assign unused_int_clip = int_hi ^ int_lo;

  logic signed [RawW-1:0]  raw;
  logic signed [OUT_W-1:0] u;
  logic                    u_hi, u_lo;
  assign raw = RawW'(p_q) + RawW'(i_cand) + RawW'(d_q);

  pid_sat #(
    .IN_W  (RawW),
    .OUT_W (OUT_W),
    .HI_LIM(OutMax),
    .LO_LIM(OutMin)
  ) u_out_sat (
    .in_i (raw),
    .out_o(u),
    .hi_o (u_hi),
    .lo_o (u_lo)
  );

  // Conditional integration: freeze the integrator while it pushes further into the clip
  logic ki_pos, ki_neg, hold_int;
  assign ki_neg   = kie_q[ProdW-1];
  assign ki_pos   = !kie_q[ProdW-1] && (kie_q != '0);
  assign hold_int = (u_hi_q && ki_pos) || (u_lo_q && ki_neg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      e_q         <= '0;
      de_q        <= '0;
      p_q         <= '0;
      kie_q       <= '0;
      d_q         <= '0;
      i_cand_q    <= '0;
      u_hi_q      <= 1'b0;
      u_lo_q      <= 1'b0;
      first_q     <= '1;
      pid_out_q   <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
        pv_q[k]     <= '0;
        sp_q[k]     <= '0;
        int_q[k]    <= '0;
        e_prev_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      // Registered at the end of SUM so the pulse coincides with the SAT cycle
      out_valid_q <= (state_q == StSum);
      if (SAMPLE_EN && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (SAMPLE_EN) begin
            ch_q <= '0;
            kp_q <= KP;
            ki_q <= KI;
            kd_q <= KD;
            for (int k = 0; k < int'(N_CH); k++) begin
              pv_q[k] <= PV_IN[k*DATA_W +: DATA_W];
              sp_q[k] <= SP_IN[k*DATA_W +: DATA_W];
            end
          end
        end
        StErr: begin
          e_q  <= e_d;
          de_q <= de_d;
        end
        StMul: begin
          p_q   <= p_d;
          kie_q <= kie_d;
          d_q   <= d_d;
        end
        StSum: begin
          i_cand_q  <= i_cand;
          u_hi_q    <= u_hi;
          u_lo_q    <= u_lo;
          pid_out_q <= u;
          out_ch_q  <= ch_q;
        end
        StSat: begin
          if (!hold_int) begin
            int_q[ch_q] <= i_cand_q;
          end
          e_prev_q[ch_q] <= e_q;
          first_q[ch_q]  <= 1'b0;
          ch_q           <= last_ch ? '0 : ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PID_out   = pid_out_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_CH    = out_ch_q;
  assign BUSY      = (state_q != StIdle);
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_pid_ctrl_mc.sv
// Directed bench for pid_ctrl_mc with a frame-level arithmetic model checked every cycle.
module tb_pid_ctrl_mc;

  localparam int     N_CH      = 4;
  localparam int     DATA_W    = 16;
  localparam int     COEF_W    = 16;
  localparam int     FRAC_BITS = 7;
  localparam int     ACC_W     = 24;
  localparam int     OUT_W     = 16;
  localparam int     CH_W      = 2;
  localparam longint INT_LIM   = 32767;
  localparam longint U_MAX     = 32767;
  localparam longint U_MIN     = -32768;

  logic                     CLK = 1'b0;
  logic                     RESET = 1'b1;
  logic                     SAMPLE_EN = 1'b0;
  logic [N_CH*DATA_W-1:0]   PV_IN = '0;
  logic [N_CH*DATA_W-1:0]   SP_IN = '0;
  logic signed [COEF_W-1:0] KP = '0, KI = '0, KD = '0;
  logic signed [OUT_W-1:0]  PID_out;
  logic                     OUT_VALID;
  logic [CH_W-1:0]          OUT_CH;
  logic                     BUSY, OVERRUN;

  pid_ctrl_mc #(
    .N_CH     (N_CH),
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .SAMPLE_EN(SAMPLE_EN),
    .PV_IN    (PV_IN),
    .SP_IN    (SP_IN),
    .KP       (KP),
    .KI       (KI),
    .KD       (KD),
    .PID_out  (PID_out),
    .OUT_VALID(OUT_VALID),
    .OUT_CH   (OUT_CH),
    .BUSY     (BUSY),
    .OVERRUN  (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Frame-level model
  typedef struct {
    int     cyc;
    int     ch;
    longint val;
  } exp_t;

  exp_t   exp_q[$];
  longint m_int   [N_CH];
  longint m_eprev [N_CH];
  bit     m_first [N_CH];
  longint last_val;
  int     last_ch;
  int     busy_lo, busy_hi;
  bit     ovr_set;
  int     ovr_cyc;
  bit     chk_en = 1'b0;

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    for (int k = 0; k < N_CH; k++) begin
      m_int[k]   = 0;
      m_eprev[k] = 0;
      m_first[k] = 1'b1;
    end
    last_val = 0;
    last_ch  = 0;
    busy_lo  = 0;
    busy_hi  = -1;
    ovr_set  = 1'b0;
    ovr_cyc  = 0;
  endfunction

  function automatic void model_frame(input int s);
    longint kp, ki, kd, sp, pv, e, de, p, kiv, d, icand, raw, u;
    kp = KP;
    ki = KI;
    kd = KD;
    for (int k = 0; k < N_CH; k++) begin
      sp    = SP_IN[k*DATA_W +: DATA_W];
      pv    = PV_IN[k*DATA_W +: DATA_W];
      e     = sp - pv;
      de    = m_first[k] ? 0 : e - m_eprev[k];
      p     = (kp * e) >>> FRAC_BITS;
      kiv   = (ki * e) >>> FRAC_BITS;
      d     = (kd * de) >>> FRAC_BITS;
      icand = clamp(m_int[k] + kiv, -INT_LIM, INT_LIM);
      raw   = p + icand + d;
      u     = clamp(raw, U_MIN, U_MAX);
      if (!((raw > U_MAX && kiv > 0) || (raw < U_MIN && kiv < 0))) m_int[k] = icand;
      m_eprev[k] = e;
      m_first[k] = 1'b0;
      exp_q.push_back('{cyc: s + 4 + 4 * k, ch: k, val: u});
    end
  endfunction

  // Per-cycle comparison against the model
  bit ev;
  always @(negedge CLK) begin
    if (chk_en) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (ev) begin
        last_val = exp_q[0].val;
        last_ch  = exp_q[0].ch;
        void'(exp_q.pop_front());
      end
      chk("out_valid", OUT_VALID, ev);
      chk("pid_out", $signed(PID_out), last_val);
      chk("out_ch", OUT_CH, last_ch);
      chk("busy", BUSY, (cyc >= busy_lo) && (cyc <= busy_hi));
      chk("overrun", OVERRUN, ovr_set && (cyc >= ovr_cyc));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_ch(input int k, input int sp, input int pv);
    SP_IN[k*DATA_W +: DATA_W] = DATA_W'(sp);
    PV_IN[k*DATA_W +: DATA_W] = DATA_W'(pv);
  endtask

  task automatic strobe(output int s);
    s = cyc;
    SAMPLE_EN = 1'b1;
    if (cyc > busy_hi) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + 4 * N_CH;
      model_frame(cyc);
    end else if (!ovr_set) begin
      ovr_set = 1'b1;
      ovr_cyc = cyc + 1;
    end
    step(1);
    SAMPLE_EN = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    step(1);
    model_clear();
    step(n - 1);
    RESET = 1'b0;
  endtask

  // Hand-computed literal expectation at an exact cycle
  task automatic check_at(input int target, input int ch, input longint val);
    repeat (500) begin
      @(negedge CLK);
      if (cyc >= target) break;
    end
    chk("lit_cycle", cyc, target);
    chk("lit_valid", OUT_VALID, 1);
    chk("lit_ch", OUT_CH, ch);
    chk("lit_val", $signed(PID_out), val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: stuck at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  int s, s2;

  initial begin
    model_clear();
    step(1);
    model_clear();
    chk_en = 1'b1;
    step(2);
    RESET = 1'b0;
    chk("rst_busy", BUSY, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_pid_out", $signed(PID_out), 0);
    step(2);

    // Proportional path; ch0 inputs change mid-frame and must not matter
    KP = 128; KI = 0; KD = 0;
    set_ch(0, 950, 900);
    set_ch(1, 500, 500);
    set_ch(2, 0, 0);
    set_ch(3, 65535, 65535);
    strobe(s);
    set_ch(0, 0, 900);
    check_at(s + 4, 0, 50);
    check_at(s + 8, 1, 0);
    check_at(s + 12, 2, 0);
    check_at(s + 16, 3, 0);
    step(3);

    // Shift rounds toward -inf
    KP = 64;
    set_ch(0, 0, 3);
    set_ch(1, 3, 0);
    strobe(s);
    check_at(s + 4, 0, -2);
    check_at(s + 8, 1, 1);
    step(10);

    // Integrator, including clamp at INT_LIM on ch3
    KP = 0; KI = 128; KD = 0;
    set_ch(0, 110, 100);
    set_ch(1, 100, 105);
    set_ch(2, 7, 7);
    set_ch(3, 30000, 10000);
    for (int f = 0; f < 3; f++) begin
      strobe(s);
      check_at(s + 4, 0, 10 * (f + 1));
      step(13);
    end

    // Derivative, first sample after reset is zero
    do_reset(2);
    KP = 0; KI = 0; KD = 128;
    set_ch(0, 200, 100);
    set_ch(1, 0, 0);
    set_ch(2, 0, 0);
    set_ch(3, 0, 0);
    strobe(s);
    check_at(s + 4, 0, 0);
    step(13);
    set_ch(0, 140, 100);
    strobe(s);
    check_at(s + 4, 0, -60);
    step(13);

    // Output saturation and anti-windup
    do_reset(2);
    KP = 128; KI = 128; KD = 0;
    set_ch(0, 65535, 0);
    set_ch(1, 0, 65535);
    for (int f = 0; f < 3; f++) begin
      strobe(s);
      check_at(s + 4, 0, 32767);
      check_at(s + 8, 1, -32768);
      step(9);
    end
    set_ch(0, 500, 500);
    strobe(s);
    check_at(s + 4, 0, 0);
    step(13);

    // Overrun at cycle 10 of a frame
    do_reset(2);
    KP = 128; KI = 0; KD = 0;
    set_ch(0, 107, 100);
    set_ch(1, 100, 107);
    set_ch(2, 0, 0);
    set_ch(3, 0, 0);
    strobe(s);
    check_at(s + 8, 1, -7);
    step(2);
    set_ch(0, 0, 100);
    strobe(s2);
    check_at(s + 12, 2, 0);
    check_at(s + 16, 3, 0);
    step(11);
    chk("overrun_sticky", OVERRUN, 1);

    // Strobe on the last SAT cycle is an overrun; the next cycle is accepted
    do_reset(2);
    strobe(s);
    step(4 * N_CH - 1);
    strobe(s2);
    strobe(s2);
    check_at(s2 + 4, 0, -100);
    chk("overrun_boundary", OVERRUN, 1);
    step(13);

    // Reset mid-frame aborts; the next frame's derivative is a first sample
    do_reset(2);
    KP = 0; KI = 0; KD = 128;
    set_ch(0, 200, 100);
    strobe(s);
    step(16);
    set_ch(0, 140, 100);
    strobe(s);
    step(5);
    do_reset(2);
    step(20);
    chk("abort_pid_out", $signed(PID_out), 0);
    set_ch(0, 170, 100);
    strobe(s);
    check_at(s + 4, 0, 0);
    step(14);

    chk("exp_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
